// File: rtl/alu_seq_ctrl_if.sv
// Job-control, load-handshake and datapath-drive bundle for alu_seq_ctrl.
// slave is the controller side; master is the side that issues jobs and observes results.
interface alu_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] op_in;
    logic [ADDR_WIDTH:0]   count_in;
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_a;
    logic [DATA_WIDTH-1:0] ld_b;
    logic                  ld_ready;
    logic                  cs_0;
    logic                  cs_1;
    logic                  wr_en_0;
    logic                  wr_en_1;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] a_out;
    logic [DATA_WIDTH-1:0] b_out;
    logic [ADDR_WIDTH-1:0] opcode_out;
    logic                  busy;
    logic                  done;
    logic                  res_valid;
    logic [ADDR_WIDTH-1:0] res_idx;

    modport slave (
        input  start, op_in, count_in, ld_valid, ld_a, ld_b,
        output ld_ready, cs_0, cs_1, wr_en_0, wr_en_1, addr_0, addr_1,
               a_out, b_out, opcode_out, busy, done, res_valid, res_idx
    );

    modport master (
        output start, op_in, count_in, ld_valid, ld_a, ld_b,
        input  ld_ready, cs_0, cs_1, wr_en_0, wr_en_1, addr_0, addr_1,
               a_out, b_out, opcode_out, busy, done, res_valid, res_idx
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the dual-RAM + ALU datapath: loads COUNT operand pairs, replays them
// with a fixed opcode and tags each datapath result with its valid strobe and index.
module alu_seq_ctrl #(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 4,
    parameter int unsigned PIPE_LAT   = 2
) (
    input logic           clk,
    input logic           reset,
    alu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = CNT_ONE << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH:0]   r_k;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_op;
    logic [PIPE_LAT-1:0]   r_vld_pipe;
    logic [ADDR_WIDTH-1:0] r_idx_pipe [PIPE_LAT];
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_opcode;

    logic [ADDR_WIDTH:0]   w_count_clamp;
    logic [ADDR_WIDTH-1:0] w_op_next;
    logic                  w_k_last;
    logic                  w_adv;
    logic                  w_issue;
    logic [PIPE_LAT-1:0]   w_vld_shift;
    logic                  w_ld_ready;
    logic                  w_cs;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_a_out;
    logic [DATA_WIDTH-1:0] w_b_out;

    // Terminal compare uses the full-width counter so a 2^ADDR_WIDTH job never aliases.
    assign w_count_clamp = (bus.count_in > MAX_COUNT) ? MAX_COUNT : bus.count_in;
    assign w_op_next     = (r_state == S_IDLE && bus.start) ? bus.op_in : r_op;
    assign w_k_last      = (r_k == r_count - CNT_ONE);
    assign w_issue       = (r_state == S_RUN);
    assign w_adv         = (r_state == S_LOAD && bus.ld_valid) || w_issue;
    assign w_vld_shift   = r_vld_pipe << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_state_next = (w_count_clamp == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (bus.ld_valid && w_k_last) w_state_next = S_RUN;
            S_RUN:   if (w_k_last) w_state_next = S_DRAIN;
            // Leave once only the final stage (the last result) is still occupied.
            S_DRAIN: if (w_vld_shift == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ld_ready = 1'b0;
        w_cs       = 1'b0;
        w_wr       = 1'b0;
        w_addr     = '0;
        w_a_out    = '0;
        w_b_out    = '0;
        unique case (r_state)
            S_LOAD: begin
                w_ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    w_cs    = 1'b1;
                    w_wr    = 1'b1;
                    w_addr  = r_k[ADDR_WIDTH-1:0];
                    w_a_out = bus.ld_a;
                    w_b_out = bus.ld_b;
                end
            end
            S_RUN: begin
                w_cs   = 1'b1;
                w_addr = r_k[ADDR_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k        <= '0;
            r_count    <= '0;
            r_op       <= '0;
            r_vld_pipe <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) r_idx_pipe[i] <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_opcode   <= '0;
        end else begin
            r_op <= w_op_next;
            if (r_state == S_IDLE && bus.start) begin
                r_count <= w_count_clamp;
                r_k     <= '0;
            end else if (w_adv) begin
                r_k <= w_k_last ? '0 : r_k + CNT_ONE;
            end
            r_vld_pipe    <= w_vld_shift | PIPE_LAT'(w_issue);
            r_idx_pipe[0] <= w_issue ? r_k[ADDR_WIDTH-1:0] : '0;
            for (int unsigned i = 1; i < PIPE_LAT; i++) r_idx_pipe[i] <= r_idx_pipe[i-1];
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= (w_state_next == S_DONE);
            r_opcode <= (w_state_next == S_IDLE) ? '0 : w_op_next;
        end
    end

    assign bus.ld_ready   = w_ld_ready;
    assign bus.cs_0       = w_cs;
    assign bus.cs_1       = w_cs;
    assign bus.wr_en_0    = w_wr;
    assign bus.wr_en_1    = w_wr;
    assign bus.addr_0     = w_addr;
    assign bus.addr_1     = w_addr;
    assign bus.a_out      = w_a_out;
    assign bus.b_out      = w_b_out;
    assign bus.opcode_out = r_opcode;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.res_valid  = r_vld_pipe[PIPE_LAT-1];
    assign bus.res_idx    = r_idx_pipe[PIPE_LAT-1];
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl: a negedge monitor logs RAM writes, reads, results
// and done pulses; each task compares them with timings computed from the job parameters.
module tb_alu_seq_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PL = 2;

    typedef struct {
        int cyc;
        int addr;
        int a;
        int b;
        int op;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    ev_t  wr_q[$];
    ev_t  rd_q[$];
    ev_t  res_q[$];
    int   done_q[$];
    int   busy_n   = 0;
    int   pair_err = 0;

    logic [DW-1:0] pa [16];
    logic [DW-1:0] pb [16];
    logic [39:0]   all_outs;

    alu_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    alu_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign all_outs = {bus.ld_ready, bus.cs_0, bus.cs_1, bus.wr_en_0, bus.wr_en_1,
                       bus.addr_0, bus.addr_1, bus.a_out, bus.b_out, bus.opcode_out,
                       bus.busy, bus.done, bus.res_valid, bus.res_idx};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int c, input int ad, input int a, input int b, input int op);
        ev_t e;
        e.cyc = c; e.addr = ad; e.a = a; e.b = b; e.op = op;
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.cs_0 && bus.wr_en_0)
            wr_q.push_back(mk_ev(cyc, int'(bus.addr_0), int'(bus.a_out), int'(bus.b_out), 0));
        if (bus.cs_0 && !bus.wr_en_0)
            rd_q.push_back(mk_ev(cyc, int'(bus.addr_0), 0, 0, int'(bus.opcode_out)));
        if (bus.res_valid) res_q.push_back(mk_ev(cyc, int'(bus.res_idx), 0, 0, 0));
        if (bus.done) done_q.push_back(cyc);
        if (bus.busy) busy_n++;
        if (bus.cs_0 !== bus.cs_1 || bus.wr_en_0 !== bus.wr_en_1 || bus.addr_0 !== bus.addr_1)
            pair_err++;
    end

    task automatic clear_mon();
        wr_q.delete(); rd_q.delete(); res_q.delete(); done_q.delete();
        busy_n = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            pa[i] = DW'($urandom);
            pb[i] = DW'($urandom);
        end
    endtask

    // Runs one job; stall_at/stall_len inserts a fixed gap, rand_stall random gaps.
    task automatic run_job(input string name, input logic [AW-1:0] op, input logic [AW:0] cnt,
                           input int stall_at, input int stall_len, input bit rand_stall);
        int c, s, t0, guard, exp_done, n;
        c = (cnt > 5'd16) ? 16 : int'(cnt);
        s = 0;
        @(posedge clk); #1;
        clear_mon();
        bus.start = 1'b1; bus.op_in = op; bus.count_in = cnt; bus.ld_valid = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_in = AW'($urandom); bus.count_in = (AW+1)'($urandom);
        for (int i = 0; i < c; i++) begin
            if (rand_stall) n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            else            n = (i == stall_at) ? stall_len : 0;
            bus.ld_valid = 1'b0;
            repeat (n) begin
                bus.ld_a = DW'($urandom); bus.ld_b = DW'($urandom);
                @(posedge clk); #1;
                bus.start = 1'($urandom);
            end
            s += n;
            bus.ld_valid = 1'b1; bus.ld_a = pa[i]; bus.ld_b = pb[i];
            @(posedge clk); #1;
            bus.start = 1'($urandom);
        end
        bus.ld_valid = 1'b0; bus.start = 1'b0;
        guard = 0;
        while (done_q.size() == 0 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        exp_done = (c == 0) ? t0 + 1 : t0 + 1 + c + s + c + PL;

        total++;
        if (done_q.size() != 1) begin
            bad++;
            $display("FAIL %s done_count got=%0d want=1", name, done_q.size());
        end else begin
            total++;
            if (done_q[0] != exp_done) begin
                bad++;
                $display("FAIL %s done_cycle got=%0d want=%0d", name, done_q[0] - t0, exp_done - t0);
            end
        end

        total++;
        if (wr_q.size() != c) begin
            bad++;
            $display("FAIL %s write_count got=%0d want=%0d", name, wr_q.size(), c);
        end else begin
            for (int i = 0; i < c; i++) begin
                total++;
                if (wr_q[i].addr != i || wr_q[i].a != int'(pa[i]) || wr_q[i].b != int'(pb[i])) begin
                    bad++;
                    $display("FAIL %s write[%0d] got addr=%0d a=%0d b=%0d want addr=%0d a=%0d b=%0d",
                             name, i, wr_q[i].addr, wr_q[i].a, wr_q[i].b, i, pa[i], pb[i]);
                end
            end
        end

        total++;
        if (rd_q.size() != c) begin
            bad++;
            $display("FAIL %s read_count got=%0d want=%0d", name, rd_q.size(), c);
        end else begin
            for (int i = 0; i < c; i++) begin
                total++;
                if (rd_q[i].addr != i || rd_q[i].cyc != t0 + 1 + c + s + i || rd_q[i].op != int'(op)) begin
                    bad++;
                    $display("FAIL %s read[%0d] got addr=%0d t=%0d op=%0d want addr=%0d t=%0d op=%0d",
                             name, i, rd_q[i].addr, rd_q[i].cyc - t0, rd_q[i].op, i, 1 + c + s + i, op);
                end
            end
        end

        total++;
        if (res_q.size() != c) begin
            bad++;
            $display("FAIL %s result_count got=%0d want=%0d", name, res_q.size(), c);
        end else begin
            for (int i = 0; i < c; i++) begin
                total++;
                if (res_q[i].addr != i || res_q[i].cyc != t0 + 1 + c + s + i + PL) begin
                    bad++;
                    $display("FAIL %s result[%0d] got idx=%0d t=%0d want idx=%0d t=%0d",
                             name, i, res_q[i].addr, res_q[i].cyc - t0, i, 1 + c + s + i + PL);
                end
            end
        end

        total++;
        if (busy_n != exp_done - t0) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_n, exp_done - t0);
        end
        total++;
        if (pair_err != 0) begin
            bad++;
            $display("FAIL %s ram_pair_mismatch got=%0d want=0", name, pair_err);
        end
    endtask

    task automatic test_reset();
        repeat (5) begin
            @(posedge clk); #1;
            bus.start = 1'($urandom); bus.op_in = AW'($urandom); bus.count_in = (AW+1)'($urandom);
            bus.ld_valid = 1'($urandom); bus.ld_a = DW'($urandom); bus.ld_b = DW'($urandom);
            @(negedge clk);
            total++;
            if (all_outs !== '0) begin
                bad++;
                $display("FAIL reset_outputs got=%h want=0", all_outs);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.ld_valid = 1'b0; bus.start = 1'b1; bus.op_in = '0; bus.count_in = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy got=%b want=1", bus.busy);
        end
        total++;
        if (bus.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_ld_ready got=%b want=1", bus.ld_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        pa[0] = 8'd5;   pb[0] = 8'd3;
        pa[1] = 8'd200; pb[1] = 8'd100;
        pa[2] = 8'd255; pb[2] = 8'd1;
        run_job("basic", '0, 5'd3, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        pa[0] = 8'd5;   pb[0] = 8'd3;
        pa[1] = 8'd200; pb[1] = 8'd100;
        pa[2] = 8'd255; pb[2] = 8'd1;
        run_job("stall", '0, 5'd3, 1, 4, 1'b0);
    endtask

    task automatic test_max_count();
        fill_random();
        run_job("count16", AW'($urandom), 5'd16, -1, 0, 1'b0);
        fill_random();
        run_job("count31", AW'($urandom), 5'd31, -1, 0, 1'b0);
    endtask

    task automatic test_zero_count();
        int t0;
        @(posedge clk); #1;
        clear_mon();
        bus.op_in = AW'($urandom); bus.count_in = '0; bus.start = 1'b1;
        t0 = cyc;
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (done_q.size() != 2 || done_q[0] != t0 + 1 || done_q[1] != t0 + 3) begin
            bad++;
            $display("FAIL zero_done got n=%0d first=%0d want n=2 at 1,3", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] - t0 : -1);
        end
        total++;
        if (busy_n != 2) begin
            bad++;
            $display("FAIL zero_busy got=%0d want=2", busy_n);
        end
        total++;
        if (wr_q.size() + rd_q.size() + res_q.size() != 0) begin
            bad++;
            $display("FAIL zero_activity got=%0d want=0", wr_q.size() + rd_q.size() + res_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        fill_random();
        @(posedge clk); #1;
        clear_mon();
        bus.start = 1'b1; bus.op_in = AW'($urandom); bus.count_in = 5'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.ld_valid = 1'b1; bus.ld_a = pa[i]; bus.ld_b = pb[i];
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        guard = 0;
        while (rd_q.size() < 2 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (rd_q.size() != 2) begin
            bad++;
            $display("FAIL midreset_reads got=%0d want=2", rd_q.size());
        end
        reset = 1'b1;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0", all_outs);
        end
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (res_q.size() + done_q.size() + rd_q.size() + wr_q.size() + busy_n != 0) begin
            bad++;
            $display("FAIL midreset_quiet got res=%0d done=%0d busy=%0d want 0", res_q.size(),
                     done_q.size(), busy_n);
        end
        reset = 1'b0;
        fill_random();
        run_job("after_reset", AW'($urandom), 5'd5, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            fill_random();
            run_job("random", AW'($urandom), (AW+1)'($urandom_range(0, 20)), -1, 0, 1'b1);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op_in = '0; bus.count_in = '0;
        bus.ld_valid = 1'b0; bus.ld_a = '0; bus.ld_b = '0;
        test_reset();
        test_basic();
        test_stall();
        test_max_count();
        test_zero_count();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
